// File: rtl/writeback_register_file_if.sv
// Purpose: bundles the WB-stage write requests and the ID/EX read ports of the register file.
// Latency: no storage here; the signals are wires between the stages and the register file.
// Backpressure: none; writes are accepted every cycle, and a bubble presents enable=0.
// Ports: master = pipeline side (drives writes and read requests, sees read data);
//        slave  = register file side (takes writes and read requests, returns read data).
interface writeback_register_file_if;
    logic        wb_register_write_enable;
    logic [4:0]  wb_register_write_address;
    logic [31:0] wb_register_write_data;
    logic        wb_register_hi_write_enable;
    logic [31:0] wb_register_hi_write_data;
    logic        wb_register_lo_write_enable;
    logic [31:0] wb_register_lo_write_data;
    logic        id_register_read_enable_1;
    logic [4:0]  id_register_read_address_1;
    logic [31:0] id_register_read_data_1;
    logic        id_register_read_enable_2;
    logic [4:0]  id_register_read_address_2;
    logic [31:0] id_register_read_data_2;
    logic [31:0] ex_register_hi_read_data;
    logic [31:0] ex_register_lo_read_data;

    modport master (
        output wb_register_write_enable, wb_register_write_address, wb_register_write_data,
        output wb_register_hi_write_enable, wb_register_hi_write_data,
        output wb_register_lo_write_enable, wb_register_lo_write_data,
        output id_register_read_enable_1, id_register_read_address_1,
        output id_register_read_enable_2, id_register_read_address_2,
        input  id_register_read_data_1, id_register_read_data_2,
        input  ex_register_hi_read_data, ex_register_lo_read_data
    );

    modport slave (
        input  wb_register_write_enable, wb_register_write_address, wb_register_write_data,
        input  wb_register_hi_write_enable, wb_register_hi_write_data,
        input  wb_register_lo_write_enable, wb_register_lo_write_data,
        input  id_register_read_enable_1, id_register_read_address_1,
        input  id_register_read_enable_2, id_register_read_address_2,
        output id_register_read_data_1, id_register_read_data_2,
        output ex_register_hi_read_data, ex_register_lo_read_data
    );
endinterface

// File: rtl/writeback_register_file.sv
// Purpose: 32x32 GPR file plus HI/LO, committed from WB, read by ID (two ports) and EX (HI/LO).
// Latency: writes commit on the rising edge; reads are combinational with same-cycle WB bypass.
// Backpressure: none; a write request is taken every cycle it is presented.
// Ports: clock, reset (synchronous, active-high), bus (slave side of writeback_register_file_if).
module writeback_register_file #(
    parameter int REGISTER_COUNT = 32,
    parameter int ZERO_REGISTER  = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    writeback_register_file_if.slave    bus
);

    localparam logic [4:0] ZERO_ADDRESS = 5'(ZERO_REGISTER);

    logic [31:0] registers [REGISTER_COUNT];
    logic [31:0] hi;
    logic [31:0] lo;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REGISTER_COUNT; i++) begin
                registers[i] <= '0;
            end
            hi <= '0;
            lo <= '0;
        end else begin
            if (bus.wb_register_write_enable && (bus.wb_register_write_address != ZERO_ADDRESS)) begin
                registers[bus.wb_register_write_address] <= bus.wb_register_write_data;
            end
            if (bus.wb_register_hi_write_enable) begin
                hi <= bus.wb_register_hi_write_data;
            end
            if (bus.wb_register_lo_write_enable) begin
                lo <= bus.wb_register_lo_write_data;
            end
        end
    end

    // Priority order matters: reset and the zero register must win over the
    // bypass, otherwise a WB write to r0 would leak into decode.
    function automatic logic [31:0] resolve_read(
        input logic        rst,
        input logic        enable,
        input logic [4:0]  address,
        input logic        write_enable,
        input logic [4:0]  write_address,
        input logic [31:0] write_data,
        input logic [31:0] stored
    );
        if (rst || !enable || (address == ZERO_ADDRESS)) begin
            return '0;
        end
        if (write_enable && (write_address == address)) begin
            return write_data;
        end
        return stored;
    endfunction

    always_comb begin
        bus.id_register_read_data_1 = resolve_read(reset,
            bus.id_register_read_enable_1, bus.id_register_read_address_1,
            bus.wb_register_write_enable, bus.wb_register_write_address,
            bus.wb_register_write_data, registers[bus.id_register_read_address_1]);
    end

    always_comb begin
        bus.id_register_read_data_2 = resolve_read(reset,
            bus.id_register_read_enable_2, bus.id_register_read_address_2,
            bus.wb_register_write_enable, bus.wb_register_write_address,
            bus.wb_register_write_data, registers[bus.id_register_read_address_2]);
    end

    always_comb begin
        bus.ex_register_hi_read_data = '0;
        bus.ex_register_lo_read_data = '0;
        if (!reset) begin
            bus.ex_register_hi_read_data = bus.wb_register_hi_write_enable ?
                                           bus.wb_register_hi_write_data : hi;
            bus.ex_register_lo_read_data = bus.wb_register_lo_write_enable ?
                                           bus.wb_register_lo_write_data : lo;
        end
    end

endmodule

// File: tb/tb_writeback_register_file.sv
module tb_writeback_register_file;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        hwe;
        logic [31:0] hwd;
        logic        lwe;
        logic [31:0] lwd;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
    } stim_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    writeback_register_file_if bus ();

    writeback_register_file dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    stim_t s;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [31:0] model_regs [32];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_stim();
        s.rst = 1'b0; s.we = 1'b0; s.wa = 5'd0; s.wd = '0;
        s.hwe = 1'b0; s.hwd = '0; s.lwe = 1'b0; s.lwd = '0;
        s.re1 = 1'b0; s.ra1 = 5'd0; s.re2 = 1'b0; s.ra2 = 5'd0;
    endtask

    function automatic logic [31:0] model_read(input logic en, input logic [4:0] addr);
        if (s.rst || !en || addr == 5'd0) return '0;
        if (s.we && s.wa == addr) return s.wd;
        return model_regs[addr];
    endfunction

    task automatic model_commit();
        if (s.rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = '0;
            model_hi = '0;
            model_lo = '0;
        end else begin
            if (s.we && s.wa != 5'd0) model_regs[s.wa] = s.wd;
            if (s.hwe) model_hi = s.hwd;
            if (s.lwe) model_lo = s.lwd;
        end
    endtask

    task automatic pop_check(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // One cycle: drive at negedge, compare the combinational outputs mid-low-phase,
    // then let the rising edge commit and advance the reference state.
    task automatic step(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] eh, input logic [31:0] el);
        @(negedge clock);
        reset                           = s.rst;
        bus.wb_register_write_enable    = s.we;
        bus.wb_register_write_address   = s.wa;
        bus.wb_register_write_data      = s.wd;
        bus.wb_register_hi_write_enable = s.hwe;
        bus.wb_register_hi_write_data   = s.hwd;
        bus.wb_register_lo_write_enable = s.lwe;
        bus.wb_register_lo_write_data   = s.lwd;
        bus.id_register_read_enable_1   = s.re1;
        bus.id_register_read_address_1  = s.ra1;
        bus.id_register_read_enable_2   = s.re2;
        bus.id_register_read_address_2  = s.ra2;
        exp_q.push_back(e1); tag_q.push_back({tag, ".rd1"});
        exp_q.push_back(e2); tag_q.push_back({tag, ".rd2"});
        exp_q.push_back(eh); tag_q.push_back({tag, ".hi"});
        exp_q.push_back(el); tag_q.push_back({tag, ".lo"});
        #2;
        pop_check(bus.id_register_read_data_1);
        pop_check(bus.id_register_read_data_2);
        pop_check(bus.ex_register_hi_read_data);
        pop_check(bus.ex_register_lo_read_data);
        @(posedge clock);
        #1;
        model_commit();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        model_hi = '0;
        model_lo = '0;

        // Reset outputs are zero even with a HI bypass and an enabled read.
        idle_stim(); s.rst = 1; s.hwe = 1; s.hwd = 32'h77; s.re1 = 1; s.ra1 = 5'd5;
        step("reset0", 0, 0, 0, 0);
        step("reset1", 0, 0, 0, 0);

        idle_stim(); s.we = 1; s.wa = 5'd5; s.wd = 32'hDEADBEEF; s.re1 = 1; s.ra1 = 5'd5;
        s.hwe = 1; s.hwd = 32'h11;
        step("wr_r5", 32'hDEADBEEF, 0, 32'h11, 0);
        idle_stim(); s.re1 = 1; s.ra1 = 5'd5;
        step("held_r5", 32'hDEADBEEF, 0, 32'h11, 0);
        idle_stim(); s.rst = 1; s.re1 = 1; s.ra1 = 5'd5;
        step("reset_mid", 0, 0, 0, 0);
        idle_stim(); s.re1 = 1; s.ra1 = 5'd5;
        step("r5_cleared", 0, 0, 0, 0);

        idle_stim(); s.we = 1; s.wa = 5'd7; s.wd = 32'h12345678; s.re2 = 1; s.ra2 = 5'd9;
        step("wr_r7", 0, 0, 0, 0);
        idle_stim(); s.re1 = 0; s.ra1 = 5'd7; s.re2 = 1; s.ra2 = 5'd7;
        step("rd_r7", 0, 32'h12345678, 0, 0);

        idle_stim(); s.we = 1; s.wa = 5'd9; s.wd = 32'hA5A5A5A5;
        s.re1 = 1; s.ra1 = 5'd9; s.re2 = 1; s.ra2 = 5'd9;
        step("bypass_r9", 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
        idle_stim(); s.we = 1; s.wa = 5'd10; s.wd = 32'h0BAD0BAD;
        s.re1 = 1; s.ra1 = 5'd9; s.re2 = 1; s.ra2 = 5'd7;
        step("stored_r9", 32'hA5A5A5A5, 32'h12345678, 0, 0);
        idle_stim(); s.re1 = 1; s.ra1 = 5'd10;
        step("stored_r10", 32'h0BAD0BAD, 0, 0, 0);

        idle_stim(); s.we = 1; s.wa = 5'd0; s.wd = 32'hFFFFFFFF;
        s.re1 = 1; s.ra1 = 5'd0; s.re2 = 1; s.ra2 = 5'd0;
        step("r0_bypass", 0, 0, 0, 0);
        idle_stim(); s.re1 = 1; s.ra1 = 5'd0; s.re2 = 1; s.ra2 = 5'd0;
        step("r0_stored", 0, 0, 0, 0);

        idle_stim(); s.hwe = 1; s.hwd = 32'h1; s.lwe = 1; s.lwd = 32'h2;
        step("hilo_wr", 0, 0, 32'h1, 32'h2);
        idle_stim();
        step("hilo_held", 0, 0, 32'h1, 32'h2);
        idle_stim(); s.hwe = 1; s.hwd = 32'h3;
        step("hi_only", 0, 0, 32'h3, 32'h2);
        idle_stim();
        step("hi_only_held", 0, 0, 32'h3, 32'h2);

        idle_stim(); s.rst = 1; s.we = 1; s.wa = 5'd3; s.wd = 32'h55;
        s.lwe = 1; s.lwd = 32'h99; s.re1 = 1; s.ra1 = 5'd3; s.re2 = 1; s.ra2 = 5'd3;
        step("rst_collide", 0, 0, 0, 0);
        idle_stim(); s.re1 = 1; s.ra1 = 5'd3; s.re2 = 1; s.ra2 = 5'd7;
        step("after_collide", 0, 0, 0, 0);

        // Randomised traffic against the reference model, with occasional resets
        // and reads biased toward the write address to exercise the bypass.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] e1, e2, eh, el;
            idle_stim();
            s.rst = ($urandom_range(0, 39) == 0);
            s.we  = 1'($urandom_range(0, 1));
            s.wa  = 5'($urandom_range(0, 31));
            s.wd  = $urandom;
            s.hwe = 1'($urandom_range(0, 1));
            s.hwd = $urandom;
            s.lwe = 1'($urandom_range(0, 1));
            s.lwd = $urandom;
            s.re1 = ($urandom_range(0, 7) != 0);
            s.ra1 = ($urandom_range(0, 2) == 0) ? s.wa : 5'($urandom_range(0, 31));
            s.re2 = ($urandom_range(0, 7) != 0);
            s.ra2 = ($urandom_range(0, 2) == 0) ? s.ra1 : 5'($urandom_range(0, 31));
            e1 = model_read(s.re1, s.ra1);
            e2 = model_read(s.re2, s.ra2);
            eh = s.rst ? 32'h0 : (s.hwe ? s.hwd : model_hi);
            el = s.rst ? 32'h0 : (s.lwe ? s.lwd : model_lo);
            step($sformatf("rand%0d", n), e1, e2, eh, el);
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_register_file.md
Name: writeback_register_file

Overview:
- Architectural state sink at the far end of the MEM/WB pipeline latch.
- Holds the 32x32 general-purpose register file plus the HI and LO registers.
- Commits the writeback-stage write requests (GPR, HI, LO) on the clock edge.
- Serves two decode-stage GPR read ports and one execute-stage HI/LO read port, with same-cycle write-to-read bypass so that no extra hazard stall is needed for the WB stage.

Parameters:
- REGISTER_COUNT, 32, number of GPRs; address width is fixed at 5 bits.
- ZERO_REGISTER, 0, index hardwired to zero; writes to it are discarded.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wb_register_write_enable  input  1  GPR write request from the WB stage
- wb_register_write_address  input  5  GPR write index
- wb_register_write_data  input  32  GPR write value
- wb_register_hi_write_enable  input  1  HI write request
- wb_register_hi_write_data  input  32  HI write value
- wb_register_lo_write_enable  input  1  LO write request
- wb_register_lo_write_data  input  32  LO write value
- id_register_read_enable_1  input  1  read port 1 enable
- id_register_read_address_1  input  5  read port 1 index
- id_register_read_data_1  output  32  read port 1 value
- id_register_read_enable_2  input  1  read port 2 enable
- id_register_read_address_2  input  5  read port 2 index
- id_register_read_data_2  output  32  read port 2 value
- ex_register_hi_read_data  output  32  current HI value, bypassed
- ex_register_lo_read_data  output  32  current LO value, bypassed

Behaviour:
- Reset: at a rising edge with reset=1, all 32 GPRs, HI and LO clear to 0. Any write presented in that cycle is dropped.
- Reset reads: while reset=1, all four read outputs are 0, regardless of bypass.
- GPR write: at a rising edge with reset=0, write_enable=1 and address != 0, the addressed register takes write_data. Otherwise the register file is unchanged.
- Zero register: writes to address 0 are ignored. Register 0 always reads 0, including under bypass.
- HI/LO writes: the HI and LO write enables are independent and may both be asserted in one cycle. Each register updates only when its own enable is 1.
- Read ports: reads are combinational (zero latency). Each port output resolves by the first matching rule:
  - reset=1 -> 0
  - read_enable=0 -> 0
  - address=0 -> 0
  - write_enable=1 and write_address == read_address -> wb_register_write_data (bypass)
  - otherwise -> stored register value
- Dual-port reads: both ports may read the same address, and both may bypass in the same cycle.
- HI/LO reads: with reset=0, ex_register_hi_read_data = wb_register_hi_write_data when hi_write_enable=1, else the stored HI. LO behaves identically.
- Stalls: no stall input. The upstream latch presents write_enable=0 during a bubble, so a stalled pipeline produces no writes here.
- Write timing: a write becomes visible in stored state one edge after being presented. It is visible through bypass in the same cycle.
- Reset mid-operation: the register file is cleared. State written before reset is not preserved.

Test Plan:
- Reset clears state: write 0xDEADBEEF to r5, then assert reset for one cycle. Read r5 on port 1 with enable=1 -> 0. Read HI -> 0.
- Store and read back: write r7=0x12345678, then next cycle read r7 on port 2 -> 0x12345678. Read r7 on port 1 with enable=0 -> 0.
- Same-cycle bypass: present r9 write 0xA5A5A5A5 with both ports reading r9. Both outputs show 0xA5A5A5A5 in the same cycle, and the stored value persists after the write is deasserted.
- Zero register: write r0=0xFFFFFFFF, bypass case and next cycle. Both ports reading r0 -> 0.
- HI/LO writes: HI=0x1, LO=0x2 simultaneously -> both visible same cycle via bypass and held afterwards. Next, HI-only write 0x3 -> HI=0x3, LO stays 0x2.
- Reset vs write collision: reset=1 with r3 write 0x55 in the same cycle. All reads show 0 during reset, and r3 reads 0 after reset deasserts.
